// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and
// pipe_hazard_ctrl (slave): operand/destination fields in, stall/flush/status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             usesrs2D;
  logic [4:0]       rdE;
  logic             memreadE;
  logic             pcsrcE;
  logic             mem_reqM;
  logic             mem_readyM;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic             mem_timeout;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1D, rs2D, usesrs2D, rdE, memreadE, pcsrcE, mem_reqM, mem_readyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout,
    input  state_o, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, usesrs2D, rdE, memreadE, pcsrcE, mem_reqM, mem_readyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout,
    output state_o, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage MIPS pipe: load-use bubbles, EX redirects and
// memory-wait freeze with watchdog. Define PIPE_HAZARD_PERF_EN to enable the perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01
  } state_t;

  state_t          stateReg;
  logic [WC_W-1:0] waitCnt;
  logic            memTimeoutReg;

  logic tmo;
  logic freeze;
  logic loadUse;
  logic stallF, stallD, stallE, stallM, flushD, flushE;

  always_comb begin
    tmo     = (stateReg == WAIT) && (waitCnt == WC_LAST) && !hz.mem_readyM;
    freeze  = hz.mem_reqM && !hz.mem_readyM && !tmo;
    loadUse = hz.memreadE && (hz.rdE != 5'd0) &&
              ((hz.rdE == hz.rs1D) || (hz.usesrs2D && (hz.rdE == hz.rs2D)));

    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    // A held EX redirect is deliberately ignored while frozen; it re-fires once unfrozen.
    if (!rst) begin
      if (freeze) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (hz.pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= RUN;
      waitCnt       <= '0;
      memTimeoutReg <= 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          if (freeze) begin
            stateReg <= WAIT;
            waitCnt  <= WC_ONE;
          end
        end
        WAIT: begin
          if (hz.mem_readyM || !hz.mem_reqM) begin
            stateReg <= RUN;
            waitCnt  <= '0;
          end else if (tmo) begin
            stateReg      <= RUN;
            waitCnt       <= '0;
            memTimeoutReg <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WC_ONE;
          end
        end
        default: begin
          stateReg <= RUN;
          waitCnt  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + CNT_W'(1);
      stallCnt <= stallCnt + CNT_W'(stallF);
      flushCnt <= flushCnt + CNT_W'(flushD);
    end
  end

  assign hz.cycle_cnt = cycleCnt;
  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`else
  assign hz.cycle_cnt = '0;
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

  assign hz.stallF      = stallF;
  assign hz.stallD      = stallD;
  assign hz.stallE      = stallE;
  assign hz.stallM      = stallM;
  assign hz.flushD      = flushD;
  assign hz.flushE      = flushE;
  assign hz.mem_timeout = memTimeoutReg;
  assign hz.state_o     = stateReg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// traffic, each cycle's expectation queued by the stimulus and checked by a monitor.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct packed {
    logic [5:0]       ctl;   // stallF stallD stallE stallM flushD flushE
    logic             tflag;
    logic [1:0]       st;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] fl;
  } obs_t;

  obs_t expQ[$];
  int   idQ[$];
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  // Reference model: frozenRun counts consecutive frozen cycles just before the current one.
  int frozenRun = 0;
  bit tmoSeen   = 0;
  int nCyc = 0, nStall = 0, nFlush = 0;

  function automatic obs_t zeroObs();
    obs_t o;
    o = '0;
    return o;
  endfunction

  task automatic rstCycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    frozenRun = 0;
    tmoSeen   = 0;
    nCyc = 0; nStall = 0; nFlush = 0;
    expQ.push_back(zeroObs());
    idQ.push_back(txn);
    txn++;
  endtask

  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic pc,
                      input logic rq, input logic rdy);
    obs_t e;
    bit   tm, fz, lu;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    hz.rs1D       = r1;
    hz.rs2D       = r2;
    hz.usesrs2D   = u2;
    hz.rdE        = rd;
    hz.memreadE   = mr;
    hz.pcsrcE     = pc;
    hz.mem_reqM   = rq;
    hz.mem_readyM = rdy;

    tm = (frozenRun == TIMEOUT - 1) && !rdy;
    fz = rq && !rdy && !tm;
    lu = mr && (rd != 0) && ((rd == r1) || (u2 && (rd == r2)));
    e = '0;
    if (fz)      e.ctl = 6'b111100;
    else if (pc) e.ctl = 6'b000011;
    else if (lu) e.ctl = 6'b110001;
    else         e.ctl = 6'b000000;
    e.tflag = tmoSeen;
    e.st    = (frozenRun > 0) ? 2'b01 : 2'b00;
`ifdef PIPE_HAZARD_PERF_EN
    e.cyc = CNT_W'(nCyc);
    e.stl = CNT_W'(nStall);
    e.fl  = CNT_W'(nFlush);
`endif
    expQ.push_back(e);
    idQ.push_back(txn);
    txn++;

    if (tm && rq) tmoSeen = 1;
    frozenRun = fz ? frozenRun + 1 : 0;
    nCyc++;
    nStall += int'(e.ctl[5]);
    nFlush += int'(e.ctl[1]);
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      obs_t e, a;
      int   id;
      e  = expQ.pop_front();
      id = idQ.pop_front();
      a.ctl   = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE};
      a.tflag = hz.mem_timeout;
      a.st    = hz.state_o;
      a.cyc   = hz.cycle_cnt;
      a.stl   = hz.stall_cnt;
      a.fl    = hz.flush_cnt;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL txn%0d outputs: got ctl=%b tmo=%b st=%b cnt=%0d/%0d/%0d, expected ctl=%b tmo=%b st=%b cnt=%0d/%0d/%0d",
                 id, a.ctl, a.tflag, a.st, a.cyc, a.stl, a.fl,
                 e.ctl, e.tflag, e.st, e.cyc, e.stl, e.fl);
      end else begin
        $display("txn%0d rst=%b ctl=%b tmo=%b st=%b cnt=%0d/%0d/%0d",
                 id, rst, a.ctl, a.tflag, a.st, a.cyc, a.stl, a.fl);
      end
    end
  end

  function automatic logic [4:0] pickReg();
    case ($urandom_range(3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  initial begin
    bit busy;
    hz.rs1D = '0; hz.rs2D = '0; hz.usesrs2D = 1'b0; hz.rdE = '0;
    hz.memreadE = 1'b0; hz.pcsrcE = 1'b0; hz.mem_reqM = 1'b0; hz.mem_readyM = 1'b0;
    rstCycle();
    rstCycle();

    // Load-use on rs1, its single-cycle bubble, then the r0 exemption.
    step(5'd8, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // rs2 only counts when the instruction reads it.
    step(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Redirect beats a simultaneous load-use.
    step(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    // Memory wait completing in the 4th cycle with a redirect held throughout.
    for (int i = 0; i < 3; i++) step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    // Memory never answers: watchdog release, sticky flag, fresh wait.
    for (int i = 0; i < 7; i++) step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset in the middle of a wait.
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    rstCycle();
    step(5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    busy = 0;
    for (int n = 0; n < 500; n++) begin
      logic rq, rdy;
      if ($urandom_range(99) == 0) begin
        rstCycle();
        busy = 0;
      end else begin
        if (!busy) busy = ($urandom_range(3) == 0);
        rq  = busy && ($urandom_range(19) != 0);
        rdy = busy && ($urandom_range(4) == 0);
        if (rdy) busy = 0;
        step(pickReg(), pickReg(), 1'($urandom_range(1)), pickReg(),
             1'($urandom_range(1)), ($urandom_range(6) == 0), rq, rdy);
      end
    end

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
